adaboost_weight_vote_reader: RTL and testbench

ADABOOST_WEIGHT_VOTE_READER -- requirements
Module: adaboost_weight_vote_reader

---
 rtl/adaboost_weight_vote_reader_pkg.sv | 22 ++
 rtl/adaboost_weight_vote_reader_if.sv | 33 +++
 rtl/adaboost_vote_accum.sv | 35 +++
 rtl/adaboost_weight_vote_reader.sv | 109 ++++++++++
 tb/tb_adaboost_weight_vote_reader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/adaboost_weight_vote_reader_pkg.sv
// Shared constants and FSM state type for the AdaBoost weighted-vote reader.
//   N_WEIGHTS   : number of stored weak-classifier weights
//   W_WIDTH     : signed weight width
//   SCORE_WIDTH : signed accumulated score width (covers +/-30*256 exactly)
//   ADDR_WIDTH  : weight memory address width
//   FINISH_ADDR : address driven in the drain cycle (one past the last weight)
package adaboost_weight_vote_reader_pkg;

    localparam int N_WEIGHTS   = 30;
    localparam int W_WIDTH     = 9;
    localparam int SCORE_WIDTH = 14;
    localparam int ADDR_WIDTH  = 5;
    localparam int FINISH_ADDR = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adaboost_weight_vote_reader_if.sv
// Weight memory bus between the vote reader (master) and the weight store (slave).
//   wmem_address : word address
//   wmem_read    : read strobe; data returns on wmem_dataout after the next edge
//   wmem_write   : write strobe (the reader never writes)
//   wmem_datain  : write data
//   wmem_dataout : registered read data (signed weight)
interface adaboost_weight_vote_reader_if
    import adaboost_weight_vote_reader_pkg::*;
#(
    parameter int W_WIDTH = adaboost_weight_vote_reader_pkg::W_WIDTH
);
    logic [ADDR_WIDTH-1:0]     wmem_address;
    logic                      wmem_read;
    logic                      wmem_write;
    logic [W_WIDTH-1:0]        wmem_datain;
    logic signed [W_WIDTH-1:0] wmem_dataout;

    modport master (
        output wmem_address,
        output wmem_read,
        output wmem_write,
        output wmem_datain,
        input  wmem_dataout
    );

    modport slave (
        input  wmem_address,
        input  wmem_read,
        input  wmem_write,
        input  wmem_datain,
        output wmem_dataout
    );
endinterface

// File: rtl/adaboost_vote_accum.sv
// Signed add/subtract-and-hold accumulator for the weighted vote.
//   clk, rst_n : clock, asynchronous active-low reset (score -> 0)
//   clr        : clear score to 0 (has priority over en)
//   en         : accumulate this cycle
//   vote       : 1 adds the weight, 0 subtracts it
//   weight     : signed weight, sign-extended to SCORE_WIDTH
//   score      : running / held score
module adaboost_vote_accum #(
    parameter int W_WIDTH     = 9,
    parameter int SCORE_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          vote,
    input  logic signed [W_WIDTH-1:0]     weight,
    output logic signed [SCORE_WIDTH-1:0] score
);

    logic signed [SCORE_WIDTH-1:0] wext;

    assign wext = {{(SCORE_WIDTH-W_WIDTH){weight[W_WIDTH-1]}}, weight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (clr) begin
            score <= '0;
        end else if (en) begin
            score <= vote ? (score + wext) : (score - wext);
        end
    end

endmodule

// File: rtl/adaboost_weight_vote_reader.sv
// AdaBoost weighted-vote reader: on start, walks the weight memory from
// address 0 to N_WEIGHTS-1 and accumulates +w[i] or -w[i] per latched vote bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request one evaluation (ignored unless idle)
//   votes      : weak-classifier outputs, bit i = 1 means +1
//   wmem       : weight memory bus (master side)
//   busy       : evaluation in progress
//   done       : one-cycle pulse when score/decision are final
//   score      : signed weighted sum, held until the next accepted start
//   decision   : 1 when score >= 0
module adaboost_weight_vote_reader
    import adaboost_weight_vote_reader_pkg::*;
#(
    parameter int N_WEIGHTS   = adaboost_weight_vote_reader_pkg::N_WEIGHTS,
    parameter int W_WIDTH     = adaboost_weight_vote_reader_pkg::W_WIDTH,
    parameter int SCORE_WIDTH = adaboost_weight_vote_reader_pkg::SCORE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_WEIGHTS-1:0]          votes,
    adaboost_weight_vote_reader_if.master wmem,
    output logic                          busy,
    output logic                          done,
    output logic signed [SCORE_WIDTH-1:0] score,
    output logic                          decision
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH-1:0] END_ADDR  = ADDR_WIDTH'(N_WEIGHTS);

    state_t               state;
    logic [N_WEIGHTS-1:0] vote_sr;   // latched votes, bit 0 pairs with the next returning weight
    logic                 acc_en;    // read strobe delayed one cycle: wmem_dataout is valid
    logic                 start_ok;

    assign start_ok         = (state == IDLE) && start;
    assign wmem.wmem_write  = 1'b0;
    assign wmem.wmem_datain = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            wmem.wmem_address <= '0;
            wmem.wmem_read    <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            decision          <= 1'b0;
            acc_en            <= 1'b0;
            vote_sr           <= '0;
        end else begin
            done   <= 1'b0;
            acc_en <= wmem.wmem_read;
            // Weights come back in address order, so shifting the latched
            // votes keeps vote i aligned with weight i.
            if (acc_en) begin
                vote_sr <= vote_sr >> 1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        vote_sr           <= votes;
                        busy              <= 1'b1;
                        wmem.wmem_address <= '0;
                        wmem.wmem_read    <= 1'b1;
                        state             <= FETCH;
                    end
                end
                FETCH: begin
                    if (wmem.wmem_address == LAST_ADDR) begin
                        wmem.wmem_address <= END_ADDR;
                        wmem.wmem_read    <= 1'b0;
                        state             <= DRAIN;
                    end else begin
                        wmem.wmem_address <= wmem.wmem_address + 1'b1;
                        wmem.wmem_read    <= 1'b1;
                    end
                end
                DRAIN: begin
                    wmem.wmem_address <= '0;
                    wmem.wmem_read    <= 1'b0;
                    state             <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    decision <= ~score[SCORE_WIDTH-1];
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    adaboost_vote_accum #(
        .W_WIDTH     (W_WIDTH),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (acc_en),
        .vote   (vote_sr[0]),
        .weight (wmem.wmem_dataout),
        .score  (score)
    );

endmodule

// File: tb/tb_adaboost_weight_vote_reader.sv
// Self-checking bench for adaboost_weight_vote_reader: directed cases plus
// randomized weights/votes checked against a plain-arithmetic score model.
module tb_adaboost_weight_vote_reader;
    import adaboost_weight_vote_reader_pkg::*;

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic [N_WEIGHTS-1:0]          votes;
    logic                          busy;
    logic                          done;
    logic signed [SCORE_WIDTH-1:0] score;
    logic                          decision;

    int checks   = 0;
    int failures = 0;

    int w [N_WEIGHTS];
    logic signed [W_WIDTH-1:0] mem [N_WEIGHTS];

    adaboost_weight_vote_reader_if #(.W_WIDTH(W_WIDTH)) bus ();

    adaboost_weight_vote_reader #(
        .N_WEIGHTS   (N_WEIGHTS),
        .W_WIDTH     (W_WIDTH),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .votes    (votes),
        .wmem     (bus.master),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .decision (decision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memory: registered read, 0 when not reading or out of range.
    always @(posedge clk) begin
        if (bus.wmem_read && (int'(bus.wmem_address) < N_WEIGHTS))
            bus.wmem_dataout <= mem[bus.wmem_address];
        else
            bus.wmem_dataout <= '0;
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_score(input logic [N_WEIGHTS-1:0] v);
        int s = 0;
        for (int i = 0; i < N_WEIGHTS; i++)
            s += v[i] ? w[i] : -w[i];
        return s;
    endfunction

    task automatic load_weights();
        for (int i = 0; i < N_WEIGHTS; i++)
            mem[i] = W_WIDTH'(w[i]);
    endtask

    // One evaluation: measures latency, records the address trace, checks result.
    task automatic run_eval(input string tag, input logic [N_WEIGHTS-1:0] v,
                            input bit extra_start, input bit scramble);
        int expv;
        int cyc;
        bit got;
        bit trace_ok;
        bit wr_seen;
        int ta[$];
        int tr[$];
        logic signed [SCORE_WIDTH-1:0] held;

        expv    = model_score(v);
        got     = 1'b0;
        wr_seen = 1'b0;
        @(negedge clk);
        votes = v;
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (!got && cyc < 80) begin
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                ta.push_back(int'(bus.wmem_address));
                tr.push_back(int'(bus.wmem_read));
                if (bus.wmem_write !== 1'b0 || bus.wmem_datain !== '0) wr_seen = 1'b1;
                @(negedge clk);
                start = extra_start && (cyc == 5 || cyc == 20);
                if (scramble) votes = N_WEIGHTS'($urandom);
                @(posedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, N_WEIGHTS + 2);

        trace_ok = (ta.size() == N_WEIGHTS + 2);
        if (trace_ok) begin
            for (int k = 0; k < N_WEIGHTS; k++)
                if (ta[k] != k || tr[k] != 1) trace_ok = 1'b0;
            if (ta[N_WEIGHTS] != FINISH_ADDR || tr[N_WEIGHTS] != 0) trace_ok = 1'b0;
            if (tr[N_WEIGHTS+1] != 0) trace_ok = 1'b0;
        end
        check({tag, "_addr_trace"}, trace_ok, 1);
        check({tag, "_no_write"}, wr_seen, 0);
        check({tag, "_score"}, score, expv);
        check({tag, "_decision"}, decision, (expv >= 0) ? 1 : 0);
        check({tag, "_busy_at_done"}, busy, 0);

        held = score;
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, done, 0);
        check({tag, "_score_held"}, score, expv);
        if (held !== score) check({tag, "_score_stable"}, score, held);
    endtask

    initial begin
        int fetch_done_cnt;
        logic [N_WEIGHTS-1:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        votes = '0;
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = 0;
        load_weights();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_score", score, 0);
        check("reset_decision", decision, 0);
        check("reset_addr", bus.wmem_address, 0);
        check("reset_read", bus.wmem_read, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All weights 1, all votes +1.
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = 1;
        load_weights();
        run_eval("ones", '1, 1'b0, 1'b0);
        check("ones_abs_score", score, 30);

        // Weight[i] = i, even votes +1, odd -1.
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = i;
        load_weights();
        run_eval("ramp", 30'h15555555, 1'b0, 1'b0);
        check("ramp_abs_score", score, -15);

        // Extremes, no overflow.
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = -256;
        load_weights();
        run_eval("min", '1, 1'b0, 1'b0);
        check("min_abs_score", score, -7680);
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = 255;
        load_weights();
        run_eval("max", '1, 1'b0, 1'b0);
        check("max_abs_score", score, 7650);
        run_eval("max_neg", '0, 1'b0, 1'b0);

        // Extra starts during evaluation and votes churning mid-run.
        for (int i = 0; i < N_WEIGHTS; i++) w[i] = $urandom_range(0, 511) - 256;
        load_weights();
        run_eval("restart_ignored", N_WEIGHTS'($urandom), 1'b1, 1'b1);

        // Reset in the middle of FETCH.
        @(negedge clk);
        votes = '1;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_score", score, 0);
        check("abort_decision", decision, 0);
        check("abort_addr", bus.wmem_address, 0);
        check("abort_read", bus.wmem_read, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) fetch_done_cnt++;
        end
        check("abort_no_done", fetch_done_cnt, 0);
        run_eval("after_abort", 30'h2AAAAAAA, 1'b0, 1'b0);

        // Randomized weights and votes.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N_WEIGHTS; i++) w[i] = $urandom_range(0, 511) - 256;
            load_weights();
            rv = N_WEIGHTS'($urandom);
            run_eval($sformatf("rand%0d", t), rv, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
